// File: rtl/regfile_bist_pkg.sv
// Shared types and constants for the register-file BIST controller.
// The optional inverted second pass is enabled with REGFILE_BIST_INV_EN.
package regfile_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned NUM_REGS = 32;
    localparam logic [31:0] PAT_MULT = 32'h0101_0101;
    localparam logic [4:0]  LAST_IDX = 5'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_bist_pattern.sv
// Combinational test-pattern generator: SEED ^ (idx * 0x01010101), optionally inverted.
// With raw low, r0 yields 0 (the value a read of r0 must return).
module regfile_bist_pattern
    import regfile_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
    input  logic [4:0]  idx,
    input  logic        invert,
    input  logic        raw,
    output logic [31:0] value
);

    logic [31:0] product;
    logic [31:0] pattern;

    always_comb begin
        product = {27'd0, idx} * PAT_MULT;
        pattern = SEED ^ product ^ {32{invert}};
        if (!raw && idx == 5'd0) begin
            value = '0;
        end else begin
            value = pattern;
        end
    end

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST: writes a pattern to all 32 registers, reads back both ports and
// latches the first mismatch. Defining REGFILE_BIST_INV_EN adds an inverted second pass.
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter logic [31:0] SEED     = 32'hA5A5_5A5A,
    parameter int          READ_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        test,
    output logic        t_ctrl_writeEnable,
    output logic [4:0]  t_ctrl_writeReg,
    output logic [4:0]  t_ctrl_readRegA,
    output logic [4:0]  t_ctrl_readRegB,
    output logic [31:0] t_data_writeReg,
    input  logic [31:0] t_data_readRegA,
    input  logic [31:0] t_data_readRegB,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_reg,
    output logic        fail_port,
    output logic [31:0] fail_data
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT);

    state_t      state, state_n;
    logic [4:0]  idx, idx_n;
    logic [1:0]  lat_cnt, lat_n;
    logic        invert;
    logic        begin_run;
    logic        compare;
    logic        finish;
    logic        failed;
    logic [4:0]  idx_b;
    logic [31:0] value_a;
    logic [31:0] value_b;
    logic        mis_a;
    logic        mis_b;

`ifdef REGFILE_BIST_INV_EN
    logic phase, phase_n;
    assign invert = phase;
`else
    assign invert = 1'b0;
`endif

    assign idx_b = LAST_IDX - idx;

    // Port A instance doubles as the write-data source (raw pattern while writing).
    regfile_bist_pattern #(.SEED(SEED)) u_pattern_a (
        .idx    (idx),
        .invert (invert),
        .raw    (state == WRITE),
        .value  (value_a)
    );

    regfile_bist_pattern #(.SEED(SEED)) u_pattern_b (
        .idx    (idx_b),
        .invert (invert),
        .raw    (1'b0),
        .value  (value_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            lat_cnt <= '0;
`ifdef REGFILE_BIST_INV_EN
            phase   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            lat_cnt <= lat_n;
`ifdef REGFILE_BIST_INV_EN
            phase   <= phase_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        lat_n     = lat_cnt;
        begin_run = 1'b0;
        compare   = 1'b0;
        finish    = 1'b0;
`ifdef REGFILE_BIST_INV_EN
        phase_n   = phase;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = WRITE;
                    idx_n     = '0;
                    lat_n     = '0;
                    begin_run = 1'b1;
`ifdef REGFILE_BIST_INV_EN
                    phase_n   = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_n = READ;
                    idx_n   = '0;
                    lat_n   = '0;
                end else begin
                    idx_n = idx + 5'd1;
                end
            end
            READ: begin
                if (lat_cnt == LAT_LAST) begin
                    compare = 1'b1;
                    lat_n   = '0;
                    if (idx == LAST_IDX) begin
                        idx_n = '0;
`ifdef REGFILE_BIST_INV_EN
                        if (!phase) begin
                            state_n = WRITE;
                            phase_n = 1'b1;
                        end else begin
                            state_n = DONE;
                            finish  = 1'b1;
                        end
`else
                        state_n = DONE;
                        finish  = 1'b1;
`endif
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end else begin
                    lat_n = lat_cnt + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Regfile-facing outputs decode from state so reset clears them without a clock.
    always_comb begin
        busy               = (state == WRITE) || (state == READ);
        test               = busy;
        t_ctrl_writeEnable = 1'b0;
        t_ctrl_writeReg    = '0;
        t_data_writeReg    = '0;
        t_ctrl_readRegA    = '0;
        t_ctrl_readRegB    = '0;
        if (state == WRITE) begin
            t_ctrl_writeEnable = 1'b1;
            t_ctrl_writeReg    = idx;
            t_data_writeReg    = value_a;
        end
        if (state == READ) begin
            t_ctrl_readRegA = idx;
            t_ctrl_readRegB = idx_b;
        end
    end

    assign mis_a = compare && (t_data_readRegA != value_a);
    assign mis_b = compare && (t_data_readRegB != value_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            failed    <= 1'b0;
            fail_reg  <= '0;
            fail_port <= 1'b0;
            fail_data <= '0;
        end else begin
            done <= finish;
            if (begin_run) begin
                pass      <= 1'b0;
                failed    <= 1'b0;
                fail_reg  <= '0;
                fail_port <= 1'b0;
                fail_data <= '0;
            end else begin
                // Port A wins a same-cycle double mismatch; only the first event is kept.
                if (!failed && (mis_a || mis_b)) begin
                    failed    <= 1'b1;
                    fail_reg  <= mis_a ? idx : idx_b;
                    fail_port <= !mis_a;
                    fail_data <= mis_a ? t_data_readRegA : t_data_readRegB;
                end
                if (finish) begin
                    pass <= !(failed || mis_a || mis_b);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench for regfile_bist with a behavioural register-file model and fault modes.
// Honours REGFILE_BIST_INV_EN for the two-pass expectations.
module tb_regfile_bist;

    localparam logic [31:0] TB_SEED = 32'h1234_5678;
`ifdef REGFILE_BIST_INV_EN
    localparam int BUSY_EXP = 192;
`else
    localparam int BUSY_EXP = 96;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        test;
    logic        we;
    logic [4:0]  wr, ra, rb;
    logic [31:0] wd, rd_a, rd_b;
    logic        busy, done, pass;
    logic [4:0]  fail_reg;
    logic        fail_port;
    logic [31:0] fail_data;

    // 0 ideal, 1 reg7 bit3 stuck-at-0, 2 r0 writable, 3 reg30 ignores 1-to-0 writes
    logic [1:0]  mode;
    logic        rf_clear;
    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_bist #(.SEED(TB_SEED), .READ_LAT(1)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .test               (test),
        .t_ctrl_writeEnable (we),
        .t_ctrl_writeReg    (wr),
        .t_ctrl_readRegA    (ra),
        .t_ctrl_readRegB    (rb),
        .t_data_writeReg    (wd),
        .t_data_readRegA    (rd_a),
        .t_data_readRegB    (rd_b),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .fail_reg           (fail_reg),
        .fail_port          (fail_port),
        .fail_data          (fail_data)
    );

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (mode == 2'd1 && a == 5'd7) return rf[7] & ~32'h0000_0008;
        return rf[a];
    endfunction

    always @(posedge clock) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we) begin
            if (mode == 2'd3 && wr == 5'd30) rf[wr] <= rf[wr] | wd;
            else if (wr != 5'd0 || mode == 2'd2) rf[wr] <= wd;
        end
        rd_a <= model_read(ra);
        rd_b <= model_read(rb);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run(input logic [1:0] m, input int extra1, input int extra2,
                       output int busy_cnt, output int done_cnt);
        mode = m;
        @(negedge clock) rf_clear = 1'b1;
        @(negedge clock) rf_clear = 1'b0;
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        check("first_busy", {31'd0, busy}, 32'd1);
        check("first_pass_clear", {31'd0, pass}, 32'd0);
        check("first_fail_reg_clear", {27'd0, fail_reg}, 32'd0);
        check("first_write", {26'd0, we, wr}, 32'h20);
        check("first_wdata", wd, TB_SEED);
        busy_cnt = 1;
        done_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            start = (busy_cnt == extra1) || (busy_cnt == extra2);
            @(negedge clock);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                break;
            end
        end
        start = 1'b0;
        check("idle_outputs_in_done", {22'd0, we, wr, ra, rb}, 32'd0);
        @(negedge clock);
        check("done_pulse_low", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        exp_pass;
        logic [4:0]  exp_reg;
        logic        exp_port;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bc, dc;
        vecs[0] = '{2'd0, 1'b1, 5'd0, 1'b0, 32'h0000_0000};
        vecs[1] = '{2'd1, 1'b0, 5'd7, 1'b0, 32'h1533_5177};
`ifdef REGFILE_BIST_INV_EN
        vecs[2] = '{2'd3, 1'b0, 5'd30, 1'b1, 32'hFFFF_FFFF};
`else
        vecs[2] = '{2'd3, 1'b1, 5'd0, 1'b0, 32'h0000_0000};
`endif
        vecs[3] = '{2'd2, 1'b0, 5'd0, 1'b0, 32'h1234_5678};
        vecs[4] = '{2'd0, 1'b1, 5'd0, 1'b0, 32'h0000_0000};

        reset = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        rf_clear = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ctrl", {19'd0, test, busy, done, pass, we, wr, fail_port}, 32'd0);
        check("rst_wdata", wd, 32'd0);
        check("rst_fail", {22'd0, fail_reg, ra}, 32'd0);
        check("rst_fail_data", fail_data, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle_after_reset", {30'd0, busy, done}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            run(vecs[v].mode, -1, -1, bc, dc);
            check($sformatf("v%0d_busy_cycles", v), bc, BUSY_EXP);
            check($sformatf("v%0d_done_count", v), dc, 32'd1);
            check($sformatf("v%0d_pass", v), {31'd0, pass}, {31'd0, vecs[v].exp_pass});
            check($sformatf("v%0d_fail_reg", v), {27'd0, fail_reg}, {27'd0, vecs[v].exp_reg});
            check($sformatf("v%0d_fail_port", v), {31'd0, fail_port}, {31'd0, vecs[v].exp_port});
            check($sformatf("v%0d_fail_data", v), fail_data, vecs[v].exp_data);
        end

        run(2'd0, 5, 40, bc, dc);
        check("ignored_start_busy", bc, BUSY_EXP);
        check("ignored_start_done", dc, 32'd1);
        check("ignored_start_pass", {31'd0, pass}, 32'd1);

        mode = 2'd1;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (19) @(negedge clock);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrun_rst_ctrl", {20'd0, test, busy, done, pass, we, wr, fail_port}, 32'd0);
        check("midrun_rst_data", wd | fail_data, 32'd0);
        check("midrun_rst_idx", {22'd0, fail_reg, ra, rb}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bc = 0;
        dc = 0;
        repeat (150) begin
            @(negedge clock);
            if (busy) bc++;
            if (done) dc++;
        end
        check("post_reset_quiet_busy", bc, 32'd0);
        check("post_reset_quiet_done", dc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_bist.md
REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 Parameter SEED, default 32'hA5A5_5A5A, base value of the write pattern.
REQ-002 Parameter READ_LAT, default 1, legal 0..3, cycles from a read-address change to valid read data.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 start  in  1  single-cycle request to run the test; honoured only in IDLE or DONE.
REQ-006 test  out  1  select for the regfile test muxes; high whenever busy.
REQ-007 t_ctrl_writeEnable  out  1  regfile write enable.
REQ-008 t_ctrl_writeReg  out  5  regfile write index.
REQ-009 t_ctrl_readRegA, t_ctrl_readRegB  out  5 each  regfile read indices.
REQ-010 t_data_writeReg  out  32  regfile write data.
REQ-011 t_data_readRegA, t_data_readRegB  in  32 each  regfile read data.
REQ-012 busy  out  1; done  out  1 (one-cycle pulse); pass  out  1 (held).
REQ-013 fail_reg  out  5; fail_port  out  1 (0=A, 1=B); fail_data  out  32, all describing the first mismatch.

Function
REQ-014 pattern(i) is SEED XOR (i * 32'h0101_0101) truncated to 32 bits; expected(0) is 0 for every pass.
REQ-015 The FSM states are IDLE, WRITE, READ, DONE; start in IDLE/DONE moves to WRITE next cycle, idx=0.
REQ-016 WRITE: one register per cycle, idx 0..31, writeEnable=1, writeReg=idx, data=pattern(idx), r0 included; after idx 31, go to READ with idx=0.
REQ-017 READ: hold readRegA=idx and readRegB=31-idx for READ_LAT+1 cycles, compare both ports on the last cycle, then advance idx.
REQ-018 After the idx 31 compare, go to DONE, pulse done, and set pass=1 only when no mismatch occurred.
REQ-019 Only the first mismatch is latched; on a same-cycle A/B mismatch, port A is reported; later mismatches leave fail_* unchanged.
REQ-020 A nominal run is 32 + 32*(READ_LAT+1) busy cycles: 96 at READ_LAT=1.
REQ-021 writeEnable is 0 outside WRITE; all t_ctrl/t_data outputs are 0 in IDLE and DONE.
REQ-022 start while busy is ignored; start in DONE clears pass and fail_* and restarts.
REQ-023 busy and test are high from the WRITE-entry cycle through the last READ cycle inclusive.

Reset
REQ-024 reset forces IDLE with test, busy, done, pass, writeEnable, every index, fail_reg, fail_port, fail_data and write data all 0, immediately, including mid-run.
REQ-025 After reset deassertion no activity occurs until a new start.

Configuration
REQ-026 When REGFILE_BIST_INV_EN is defined, a second WRITE+READ pass follows, using ~pattern(i) (r0 still expects 0), with done after pass two: 192 cycles at READ_LAT=1.
REQ-027 When REGFILE_BIST_INV_EN is undefined, only the single true-pattern pass exists and no inversion logic is built.

Structure
REQ-028 Package regfile_bist_pkg shall hold the state enum, the 32'h0101_0101 multiplier constant, and the register-count constant 32.
REQ-029 One sub-module, regfile_bist_pattern, shall compute the combinational expected value from idx, SEED and the invert flag; the FSM stays in regfile_bist.

Verification
REQ-030 Ideal regfile model, SEED=32'h1234_5678, READ_LAT=1, start -> busy 96 cycles, done pulse, pass=1, fail_* = 0.
REQ-031 Same setup, reg 7 bit 3 stuck at 0 -> pass=0, fail_reg=7, fail_port=0, fail_data=32'h1533_5177.
REQ-032 Model where r0 is writable -> pass=0, fail_reg=0, fail_port=0, fail_data=pattern(0)=32'h1234_5678.
REQ-033 start pulsed at cycles 5 and 40 of a run -> both ignored, single done at cycle 96; reset at cycle 20 -> all outputs 0 immediately, no done.
REQ-034 REGFILE_BIST_INV_EN defined, ideal model -> busy 192 cycles, pass=1; model whose reg 30 ignores 1-to-0 writes -> pass=0, fail_reg=30 reported in pass two.
